// File: rtl/stall_controller.sv
// ---------------------------------------------------------------------------
// stall_controller
//
// Purpose:
//    Collects the stall and flush requests for the 5-stage MIPS pipeline and
//    turns them into per-stage write enables, a bubble select, a flush strobe
//    and the data-memory access strobe. While a multi-cycle data-memory access
//    is outstanding, the whole pipeline is frozen. A watchdog moves the block
//    into a sticky error state if the memory never acknowledges.
//
// Parameters:
//    MEM_TIMEOUT  maximum number of cycles spent waiting for an ack (1..255)
//    CNT_W        width of the stall cycle counter
//
// Configuration macro:
//    STALL_CNT_EN  when defined, a saturating stall cycle counter is built and
//                  reported on stall_cnt_o; otherwise stall_cnt_o is tied to 0
//
// Ports:
//    clk_i           clock, rising edge
//    rst_i           asynchronous active-high reset
//    is_stall        load-use stall request from hazard detection
//    flush_i         branch taken in ID, squash IF/ID
//    mem_req_i       the MEM-stage instruction accesses data memory
//    mem_ack_i       data memory has completed the current access
//    pc_wr_o         PC write enable
//    if_id_wr_o      IF/ID write enable
//    if_id_flush_o   clear IF/ID to a NOP
//    id_ex_bubble_o  select zero control into ID/EX
//    pipe_wr_o       write enable shared by ID/EX, EX/MEM and MEM/WB
//    mem_stb_o       access strobe to data memory
//    err_o           memory timeout occurred, sticky until reset
//    stall_cnt_o     number of stalled cycles (saturating)
// ---------------------------------------------------------------------------
module stall_controller #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             is_stall,
   input  logic             flush_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             pc_wr_o,
   output logic             if_id_wr_o,
   output logic             if_id_flush_o,
   output logic             id_ex_bubble_o,
   output logic             pipe_wr_o,
   output logic             mem_stb_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_t     state;
   state_t     state_next;
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_next;

   logic       release_pipe;
   logic       pc_wr;
   logic       if_id_wr;
   logic       if_id_flush;
   logic       id_ex_bubble;
   logic       pipe_wr;
   logic       mem_stb;
   logic       err;

   // State register and wait counter. The wait counter holds the number of
   // the current WAIT cycle (1 in the first one) so the timeout compare can
   // be done directly against MEM_TIMEOUT.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= ST_RUN;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Next-state and output decode. Everything defaults to a full freeze;
   // release_pipe marks the cycles where the memory is not holding the
   // pipeline, and the load-use stall and flush rules are then applied once
   // below so RUN and the WAIT ack cycle share the same priority logic.
   // An ack is only looked at while the strobe is high: in RUN the strobe is
   // mem_req_i, and in ERR the ack is not examined at all.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      release_pipe  = 1'b0;
      pc_wr         = 1'b0;
      if_id_wr      = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      pipe_wr       = 1'b0;
      mem_stb       = 1'b0;
      err           = 1'b0;

      unique case (state)
         ST_RUN: begin
            mem_stb = mem_req_i;
            if (mem_req_i && !mem_ack_i) begin
               state_next    = ST_WAIT;
               wait_cnt_next = 8'd1;
            end else begin
               release_pipe = 1'b1;
            end
         end
         ST_WAIT: begin
            mem_stb = 1'b1;
            if (mem_ack_i) begin
               state_next    = ST_RUN;
               wait_cnt_next = 8'd0;
               release_pipe  = 1'b1;
            end else if (wait_cnt >= TIMEOUT_CNT) begin
               state_next = ST_ERR;
            end else begin
               wait_cnt_next = wait_cnt + 8'd1;
            end
         end
         ST_ERR: begin
            err = 1'b1;
         end
         default: begin
            state_next    = ST_RUN;
            wait_cnt_next = 8'd0;
         end
      endcase

      // A load-use stall holds PC and IF/ID and injects a bubble; the
      // pending branch flush is dropped because the branch re-resolves once
      // the stall clears.
      if (release_pipe) begin
         if (is_stall) begin
            id_ex_bubble = 1'b1;
            pipe_wr      = 1'b1;
         end else begin
            pc_wr       = 1'b1;
            if_id_wr    = 1'b1;
            pipe_wr     = 1'b1;
            if_id_flush = flush_i;
         end
      end
   end

   // While reset is held every output is forced low, so an in-flight access
   // loses its strobe in the same cycle reset arrives.
   assign pc_wr_o        = pc_wr        & ~rst_i;
   assign if_id_wr_o     = if_id_wr     & ~rst_i;
   assign if_id_flush_o  = if_id_flush  & ~rst_i;
   assign id_ex_bubble_o = id_ex_bubble & ~rst_i;
   assign pipe_wr_o      = pipe_wr      & ~rst_i;
   assign mem_stb_o      = mem_stb      & ~rst_i;
   assign err_o          = err          & ~rst_i;

`ifdef STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt;

   // Saturating count of cycles in which the PC was held, covering both
   // memory freezes and load-use stalls. Counting stops in ERR so the value
   // reflects the stalls seen up to the timeout.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
      end else if (!pc_wr && (state != ST_ERR) && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt_o = rst_i ? '0 : stall_cnt;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/stall_controller.md
# stall_controller

Pipeline-side consumer of stall and flush requests for the 5-stage MIPS core. It takes the load-use stall from hazard detection, the branch flush from ID, and the handshake with the multi-cycle data memory. It turns these into per-stage write enables, bubble inserts and flush strobes, and freezes the whole pipeline while a memory access is outstanding. A watchdog raises an error if the memory never acknowledges.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 64: maximum cycles spent in WAIT before entering ERR. Legal range is 1..255.
- `CNT_W`, default 16: width of the stall cycle counter.

Ports:
- `clk_i`, in, 1: clock. All state updates on the rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `is_stall`, in, 1: load-use stall request from hazard detection.
- `flush_i`, in, 1: branch taken in ID; squash the instruction in IF/ID.
- `mem_req_i`, in, 1: the instruction in the MEM stage accesses data memory.
- `mem_ack_i`, in, 1: data memory has completed the current access.
- `pc_wr_o`, out, 1: PC write enable.
- `if_id_wr_o`, out, 1: IF/ID register write enable.
- `if_id_flush_o`, out, 1: clear IF/ID to a NOP.
- `id_ex_bubble_o`, out, 1: select zero control into ID/EX.
- `pipe_wr_o`, out, 1: write enable shared by ID/EX, EX/MEM and MEM/WB.
- `mem_stb_o`, out, 1: access strobe to data memory.
- `err_o`, out, 1: memory timeout occurred. Sticky until reset.
- `stall_cnt_o`, out, CNT_W: number of stalled cycles.

## Operation
- States are RUN, WAIT and ERR. The state register and the counters are sequential; all enable and strobe outputs are combinational from the state and the inputs.
- Output priority is memory freeze, then load-use stall, then flush.
- RUN state:
  - `mem_stb_o` = `mem_req_i`.
  - If `mem_req_i` is 1 and `mem_ack_i` is 0: freeze. `pc_wr_o`, `if_id_wr_o` and `pipe_wr_o` are all 0, `id_ex_bubble_o` is 0 and `if_id_flush_o` is 0. The next state is WAIT and the wait counter loads 1.
  - If `mem_req_i` and `mem_ack_i` are both 1 (zero-wait access): no freeze; the lower-priority rules apply.
  - Else if `is_stall` is 1: `pc_wr_o` = 0, `if_id_wr_o` = 0, `id_ex_bubble_o` = 1, `pipe_wr_o` = 1. `flush_i` is ignored this cycle; the branch re-resolves after the stall.
  - Else: all write enables are 1. `if_id_flush_o` = `flush_i` and `id_ex_bubble_o` = 0.
- WAIT state:
  - `mem_stb_o` = 1, held regardless of `mem_req_i`.
  - Full freeze as above while `mem_ack_i` is 0. The wait counter increments each cycle.
  - When `mem_ack_i` is 1: the outputs follow the RUN rules for `is_stall` and `flush_i` in that same cycle, and the next state is RUN.
  - If the wait counter reaches `MEM_TIMEOUT` with `mem_ack_i` still 0, the next state is ERR.
  - If `mem_ack_i` is 1 in the same cycle the counter reaches `MEM_TIMEOUT`, the ack wins and the next state is RUN.
- ERR state:
  - Full freeze, `mem_stb_o` = 0, `err_o` = 1.
  - Only reset leaves this state.
- Reset, applied asynchronously:
  - The state goes to RUN and the wait counter and `stall_cnt_o` clear to 0.
  - While `rst_i` is 1, every output is forced to 0. This includes `pc_wr_o`, `if_id_wr_o`, `pipe_wr_o`, `mem_stb_o`, `err_o` and `stall_cnt_o`.
  - Reset asserted in the middle of WAIT abandons the access; `mem_stb_o` drops the same cycle.

## Timing
- Enable outputs have zero latency: they are combinational from the inputs in the same cycle.
- A memory access with N wait cycles freezes the pipeline for exactly N cycles. The strobe is held high for N+1 cycles, including the ack cycle.
- ERR is entered on the edge that ends the `MEM_TIMEOUT`-th WAIT cycle with no ack.
- The stall counter increments on every edge where `pc_wr_o` was 0, whether the stall came from a freeze or from a load-use stall.
  - The counter saturates at 2^CNT_W−1 and does not wrap.
  - It is not incremented while in ERR.
- Handshake rule: `mem_ack_i` is sampled only while `mem_stb_o` is 1. An ack arriving with no strobe is ignored.

## Configuration
- `STALL_CNT_EN` defined: the saturating stall counter is built and `stall_cnt_o` reports it.
- `STALL_CNT_EN` undefined: no counter flops are built and `stall_cnt_o` is tied to 0. All other behaviour is identical.

## Test plan
- Reset is pulsed in the middle of a cycle with all inputs at 1 → all outputs are 0 immediately. After release with no requests → `pc_wr_o` = `if_id_wr_o` = `pipe_wr_o` = 1 and the state is RUN.
- `is_stall` = 1 and `flush_i` = 1 for one cycle, no memory request → `pc_wr_o` = 0, `if_id_wr_o` = 0, `id_ex_bubble_o` = 1, `if_id_flush_o` = 0. The counter advances from 0 to 1.
- `mem_req_i` = 1 with `mem_ack_i` arriving 3 cycles later → 3 frozen cycles, `mem_stb_o` high for 4 cycles, and all enables return to 1 in the ack cycle. The counter reads 3.
- `MEM_TIMEOUT` = 4, `mem_req_i` = 1 and `mem_ack_i` never asserts → after 4 WAIT cycles, `err_o` = 1, `mem_stb_o` = 0 and the pipeline stays frozen. A later `mem_ack_i` has no effect and `rst_i` clears everything.
- Zero-wait access (`mem_req_i` = `mem_ack_i` = 1) together with `flush_i` = 1 → no freeze, `if_id_flush_o` = 1, and the state stays RUN.
- `CNT_W` = 4 with 20 consecutive stall cycles → `stall_cnt_o` saturates at 15. With `STALL_CNT_EN` undefined → `stall_cnt_o` stays at 0 throughout.
